// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator.
//   state_t      : FSM states of bounce_generator
//   LFSR_W       : LFSR width
//   LFSR_TAPS    : Fibonacci tap mask for taps 16,14,13,11
//   DEFAULT_SEED : reset value of the LFSR
//   lfsr_step()  : one LFSR advance
package bounce_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      BOUNCE = 1'b1
   } state_t;

   localparam int unsigned         LFSR_W       = 16;
   localparam logic [LFSR_W-1:0]   LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 16'hACE1;

   // Shift left, feeding the parity of the tapped bits into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Fibonacci LFSR.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, loads SEED (0 becomes 1)
//   o_lfsr  : full LFSR state, advances every cycle out of reset
module bounce_lfsr
   import bounce_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic [LFSR_W-1:0] o_lfsr
);

   // An all-zero state would lock up the register.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] r_lfsr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_lfsr <= SEED_EFF;
      else          r_lfsr <= lfsr_step(r_lfsr);
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns a clean level into a bouncing level.
// Each clean edge (with bounce_en=1) starts a burst of pseudo-random toggles
// lasting BOUNCE_WINDOW cycles, after which the output settles on the level.
//   CLK          : clock
//   RST          : asynchronous active-low reset
//   clean_in     : clean level, synchronous to CLK
//   bounce_en    : 1 = emulate bounce, 0 = registered pass-through
//   noisy_out    : emulated bouncing level (registered)
//   busy         : high while a burst is in progress (registered)
//   bounce_count : transitions in the last burst, saturating
//                  (present only when BOUNCE_STATS_EN is defined)
module bounce_generator
   import bounce_pkg::*;
#(
   parameter int unsigned       BOUNCE_WINDOW = 64,
   parameter int unsigned       MIN_DWELL     = 2,
   parameter int unsigned       DWELL_BITS    = 3,
   parameter int unsigned       COUNTER_WIDTH = 8,
   parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clean_in,
   input  logic                     bounce_en,
   output logic                     noisy_out,
   output logic                     busy
`ifdef BOUNCE_STATS_EN
   ,
   output logic [COUNTER_WIDTH-1:0] bounce_count
`endif
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] WIN_LOAD   = COUNTER_WIDTH'(BOUNCE_WINDOW - 1);
   localparam logic [COUNTER_WIDTH-1:0] DWELL_BASE = COUNTER_WIDTH'(MIN_DWELL - 1);
   localparam logic [LFSR_W-1:0]        DWELL_MASK = LFSR_W'((32'd1 << DWELL_BITS) - 32'd1);

   state_t                   r_state, w_state_nxt;
   logic                     r_noisy, w_noisy_nxt;
   logic                     r_busy, w_busy_nxt;
   logic                     r_target, w_target_nxt;
   logic                     r_clean_q;
   logic [COUNTER_WIDTH-1:0] r_win_cnt, w_win_nxt;
   logic [COUNTER_WIDTH-1:0] r_dwell_cnt, w_dwell_nxt;
   logic [COUNTER_WIDTH-1:0] w_dwell_load;
   logic [LFSR_W-1:0]        w_lfsr;
   logic                     w_edge;

   bounce_lfsr #(.SEED(SEED)) u_lfsr (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .o_lfsr  (w_lfsr)
   );

   assign w_edge       = clean_in ^ r_clean_q;
   // Random gap between toggles: MIN_DWELL .. MIN_DWELL+2^DWELL_BITS-1 cycles.
   assign w_dwell_load = DWELL_BASE + COUNTER_WIDTH'(w_lfsr & DWELL_MASK);

`ifdef BOUNCE_STATS_EN
   logic [COUNTER_WIDTH-1:0] r_count, w_count_nxt, w_count_inc;
   assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_ONE;
`endif

   // Next-state and output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_noisy_nxt  = r_noisy;
      w_busy_nxt   = r_busy;
      w_target_nxt = r_target;
      w_win_nxt    = r_win_cnt;
      w_dwell_nxt  = r_dwell_cnt;
`ifdef BOUNCE_STATS_EN
      w_count_nxt  = r_count;
`endif
      case (r_state)
         IDLE: begin
            if (!bounce_en) begin
               w_noisy_nxt = clean_in;
            end else if (w_edge) begin
               w_state_nxt  = BOUNCE;
               w_busy_nxt   = 1'b1;
               w_target_nxt = clean_in;
               w_noisy_nxt  = ~r_noisy;
               w_win_nxt    = WIN_LOAD;
               w_dwell_nxt  = w_dwell_load;
`ifdef BOUNCE_STATS_EN
               w_count_nxt  = CNT_ONE;
`endif
            end
         end
         BOUNCE: begin
            if (!bounce_en) begin
               w_state_nxt = IDLE;
               w_busy_nxt  = 1'b0;
               w_noisy_nxt = clean_in;
            end else if (w_edge) begin
               // Retrigger restarts the window; the toggle cadence carries on.
               w_target_nxt = clean_in;
               w_win_nxt    = WIN_LOAD;
               if (r_dwell_cnt != '0) w_dwell_nxt = r_dwell_cnt - CNT_ONE;
            end else if (r_win_cnt == '0) begin
               w_state_nxt = IDLE;
               w_busy_nxt  = 1'b0;
               w_noisy_nxt = r_target;
`ifdef BOUNCE_STATS_EN
               if (r_target != r_noisy) w_count_nxt = w_count_inc;
`endif
            end else begin
               w_win_nxt = r_win_cnt - CNT_ONE;
               if (r_dwell_cnt == '0) begin
                  w_noisy_nxt = ~r_noisy;
                  w_dwell_nxt = w_dwell_load;
`ifdef BOUNCE_STATS_EN
                  w_count_nxt = w_count_inc;
`endif
               end else begin
                  w_dwell_nxt = r_dwell_cnt - CNT_ONE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= IDLE;
         r_noisy     <= 1'b0;
         r_busy      <= 1'b0;
         r_target    <= 1'b0;
         r_clean_q   <= 1'b0;
         r_win_cnt   <= '0;
         r_dwell_cnt <= '0;
`ifdef BOUNCE_STATS_EN
         r_count     <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_noisy     <= w_noisy_nxt;
         r_busy      <= w_busy_nxt;
         r_target    <= w_target_nxt;
         r_clean_q   <= clean_in;
         r_win_cnt   <= w_win_nxt;
         r_dwell_cnt <= w_dwell_nxt;
`ifdef BOUNCE_STATS_EN
         r_count     <= w_count_nxt;
`endif
      end
   end

   assign noisy_out = r_noisy;
   assign busy      = r_busy;
`ifdef BOUNCE_STATS_EN
   assign bounce_count = r_count;
`endif

endmodule
